// File: rtl/mem_fill_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_fill_arbiter
//  Purpose  : Shares one pipelined main memory between the I-cache miss
//             handler and the D-cache miss / write-through path. Grants one
//             requester at a time, sequences BLOCK_WORDS back-to-back word
//             reads per miss, steers returning data into the granted cache,
//             pulses a fill-done strobe, and passes D-cache stores to memory
//             while idle.
//  Ports    : clk, rst_n (async, active-low)
//             ic_miss/ic_miss_addr, dc_miss/dc_miss_addr   miss requests
//             dc_wr/dc_wr_addr/dc_wr_data, dc_wr_ack        write-through
//             mem_en/mem_wr/mem_addr/mem_wdata              memory request
//             mem_rdata/mem_rvalid                          memory return
//             ic_fill_we/dc_fill_we/fill_idx/fill_data      cache fill port
//             ic_fill_done/dc_fill_done                     completion pulses
//             ic_busy/dc_busy                               stall indicators
//  Revision : 1.0  initial release
// ============================================================================
module mem_fill_arbiter #(
   parameter int BLOCK_WORDS = 8,
   parameter int ADDR_W      = 16
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           ic_miss,
   input  logic [ADDR_W-1:0]              ic_miss_addr,
   input  logic                           dc_miss,
   input  logic [ADDR_W-1:0]              dc_miss_addr,
   input  logic                           dc_wr,
   input  logic [ADDR_W-1:0]              dc_wr_addr,
   input  logic [15:0]                    dc_wr_data,
   output logic                           mem_en,
   output logic                           mem_wr,
   output logic [ADDR_W-1:0]              mem_addr,
   output logic [15:0]                    mem_wdata,
   input  logic [15:0]                    mem_rdata,
   input  logic                           mem_rvalid,
   output logic                           ic_fill_we,
   output logic                           dc_fill_we,
   output logic [$clog2(BLOCK_WORDS)-1:0] fill_idx,
   output logic [15:0]                    fill_data,
   output logic                           ic_fill_done,
   output logic                           dc_fill_done,
   output logic                           dc_wr_ack,
   output logic                           ic_busy,
   output logic                           dc_busy
);

   localparam int IDX_W = $clog2(BLOCK_WORDS);
   localparam int OFF_W = IDX_W + 1;              // byte-offset bits in a block
   localparam int CNT_W = IDX_W + 1;              // counters must reach BLOCK_WORDS

   localparam logic [CNT_W-1:0]  BLOCK_CNT  = CNT_W'(BLOCK_WORDS);
   localparam logic [CNT_W-1:0]  LAST_RCV   = CNT_W'(BLOCK_WORDS - 1);
   localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(ADDR_W'((1 << OFF_W) - 1));

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      I_FILL = 3'd1,
      D_FILL = 3'd2,
      I_DONE = 3'd3,
      D_DONE = 3'd4
   } state_t;

   state_t              state, state_nxt;
   logic [CNT_W-1:0]    issue_cnt, issue_nxt;
   logic [CNT_W-1:0]    rcv_cnt, rcv_nxt;
   logic [ADDR_W-1:0]   base, base_nxt;
   logic [ADDR_W-1:0]   word_off;
   logic                is_d;

   // Byte offset of the word being issued; the block is aligned so plain
   // addition never carries across the block boundary.
   assign word_off = ADDR_W'({issue_cnt[IDX_W-1:0], 1'b0});
   assign is_d     = (state == D_FILL);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         issue_cnt <= '0;
         rcv_cnt   <= '0;
         base      <= '0;
      end else begin
         state     <= state_nxt;
         issue_cnt <= issue_nxt;
         rcv_cnt   <= rcv_nxt;
         base      <= base_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      issue_nxt    = issue_cnt;
      rcv_nxt      = rcv_cnt;
      base_nxt     = base;
      mem_en       = 1'b0;
      mem_wr       = 1'b0;
      mem_addr     = '0;
      mem_wdata    = '0;
      ic_fill_we   = 1'b0;
      dc_fill_we   = 1'b0;
      fill_idx     = '0;
      fill_data    = '0;
      ic_fill_done = 1'b0;
      dc_fill_done = 1'b0;
      dc_wr_ack    = 1'b0;
      ic_busy      = 1'b0;
      dc_busy      = 1'b0;

      // Combinational outputs are forced low while reset is asserted so the
      // whole output bundle goes quiet asynchronously, including the
      // idle-state store path and the read-data passthrough.
      if (rst_n) begin
         fill_idx  = rcv_cnt[IDX_W-1:0];
         fill_data = mem_rdata;

         case (state)
            IDLE: begin
               if (dc_wr) begin
                  mem_en    = 1'b1;
                  mem_wr    = 1'b1;
                  mem_addr  = dc_wr_addr;
                  mem_wdata = dc_wr_data;
                  dc_wr_ack = 1'b1;
               end else if (dc_miss) begin
                  base_nxt  = dc_miss_addr & ALIGN_MASK;
                  state_nxt = D_FILL;
               end else if (ic_miss) begin
                  base_nxt  = ic_miss_addr & ALIGN_MASK;
                  state_nxt = I_FILL;
               end
            end

            I_FILL, D_FILL: begin
               dc_busy = is_d;
               ic_busy = !is_d;

               // Issue side runs freely; it does not wait on returns.
               if (issue_cnt < BLOCK_CNT) begin
                  mem_en    = 1'b1;
                  mem_addr  = base + word_off;
                  issue_nxt = issue_cnt + CNT_W'(1);
               end

               // Receive side is driven purely by mem_rvalid.
               if (mem_rvalid) begin
                  dc_fill_we = is_d;
                  ic_fill_we = !is_d;
                  if (rcv_cnt == LAST_RCV) begin
                     state_nxt = is_d ? D_DONE : I_DONE;
                     issue_nxt = '0;
                     rcv_nxt   = '0;
                  end else begin
                     rcv_nxt = rcv_cnt + CNT_W'(1);
                  end
               end
            end

            I_DONE: begin
               ic_busy      = 1'b1;
               ic_fill_done = 1'b1;
               state_nxt    = IDLE;
            end

            D_DONE: begin
               dc_busy      = 1'b1;
               dc_fill_done = 1'b1;
               state_nxt    = IDLE;
            end

            default: state_nxt = IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: doc/mem_fill_arbiter.md
Name: mem_fill_arbiter

Overview:
- Shares the single pipelined main memory between the I-cache miss handler and the D-cache miss/write-through path.
- Grants one requester at a time.
- For each cache miss, it sequences an 8-word block fill: it issues back-to-back word addresses, steers the returning data into the granted cache, and pulses a done signal.
- It also passes D-cache write-through stores to memory when idle.
- Sits between the caches and the memory model; the pipeline's stall logic keys off the busy outputs.

Parameters:
BLOCK_WORDS, 8, 16-bit words per cache block (power of 2; block = 2*BLOCK_WORDS bytes)
ADDR_W, 16, byte address width

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
ic_miss  in  1  I-cache miss request, level, held until ic_fill_done
ic_miss_addr  in  ADDR_W  I-cache miss byte address
dc_miss  in  1  D-cache miss request, level, held until dc_fill_done
dc_miss_addr  in  ADDR_W  D-cache miss byte address
dc_wr  in  1  D-cache write-through request, held until dc_wr_ack
dc_wr_addr  in  ADDR_W  store byte address
dc_wr_data  in  16  store data
mem_en  out  1  memory access this cycle
mem_wr  out  1  1=write, 0=read (valid when mem_en)
mem_addr  out  ADDR_W  memory byte address
mem_wdata  out  16  memory write data
mem_rdata  in  16  memory read data
mem_rvalid  in  1  mem_rdata valid; one pulse per issued read, in order
ic_fill_we  out  1  write mem_rdata into I-cache block at ic_fill_idx
dc_fill_we  out  1  same for D-cache
fill_idx  out  log2(BLOCK_WORDS)  word index within block of current returning word
fill_data  out  16  mem_rdata passthrough
ic_fill_done  out  1  one-cycle pulse, I-cache block complete
dc_fill_done  out  1  one-cycle pulse, D-cache block complete
dc_wr_ack  out  1  store accepted this cycle
ic_busy  out  1  I-side fill in progress (state I_FILL or I_DONE)
dc_busy  out  1  D-side fill in progress (state D_FILL or D_DONE)

Behaviour:
- Reset (async, rst_n=0): state IDLE, issue_cnt=0, rcv_cnt=0, base=0; all outputs 0.
- States: IDLE, I_FILL, D_FILL, I_DONE, D_DONE.
- IDLE priority, evaluated each cycle:
  - dc_wr: combinational mem_en=1, mem_wr=1, mem_addr=dc_wr_addr, mem_wdata=dc_wr_data, dc_wr_ack=1; stay IDLE.
  - else dc_miss: latch base=dc_miss_addr with low log2(2*BLOCK_WORDS) bits cleared; go D_FILL.
  - else ic_miss: same with ic_miss_addr; go I_FILL.
- Write acceptance: dc_wr_ack is never asserted outside IDLE; the store waits.
- *_FILL issue:
  - While issue_cnt<BLOCK_WORDS: mem_en=1, mem_wr=0, mem_addr=base+2*issue_cnt; issue_cnt increments each cycle.
  - All BLOCK_WORDS reads issue on consecutive cycles starting the first cycle in FILL.
  - No issue once issue_cnt==BLOCK_WORDS.
- *_FILL receive:
  - On each mem_rvalid: fill_idx=rcv_cnt, fill_data=mem_rdata, and the granted side's *_fill_we=1 (combinational, same cycle); rcv_cnt increments.
  - Receive overlaps issue; the arbiter relies only on mem_rvalid, not on a fixed latency.
- Completion:
  - The edge where the BLOCK_WORDS-th mem_rvalid is accepted moves the state to *_DONE and clears both counters.
  - *_DONE asserts *_fill_done for exactly one cycle, then returns to IDLE.
  - A request pending in IDLE is arbitrated the cycle after DONE.
- Grant is held for the whole fill: a new higher-priority request, or deassertion of the granted miss, does not abort or preempt it.
- mem_rvalid seen in IDLE or DONE is ignored (no fill_we).
- Reset mid-fill: immediate return to IDLE, counters cleared. Post-reset in-flight returns are ignored per the rule above.
- Address arithmetic is modulo 2^ADDR_W. The block is aligned, so no wrap occurs within a block.
- Latency: with memory latency L, a fill occupies BLOCK_WORDS+L cycles in FILL, plus 1 in DONE.

Test Plan:
- Reset, then ic_miss=1 with ic_miss_addr=0x0036, memory L=4 -> reads issued to 0x0030,0x0032,…,0x003E on 8 consecutive cycles. ic_fill_we with fill_idx 0..7 on cycles 4..11 after the first issue. ic_fill_done one pulse at cycle 12. ic_busy high throughout; dc_fill_we never asserted.
- dc_miss (0xA004) and ic_miss (0x1000) raised in the same cycle -> D fill of 0xA000–0xA00E completes and dc_fill_done pulses. The I fill starts the cycle after D_DONE, with its first read at 0x1000.
- dc_wr (addr 0x2002, data 0xBEEF) in IDLE together with dc_miss -> same cycle: mem_wr=1, mem_addr=0x2002, mem_wdata=0xBEEF, dc_wr_ack=1. The D fill starts the next cycle.
- dc_wr raised mid-I fill -> dc_wr_ack stays 0 until IDLE after ic_fill_done, then acks on the first IDLE cycle. The I fill is not disturbed.
- rst_n pulsed low after 3 returned words of a fill -> all outputs 0 asynchronously. The remaining mem_rvalid pulses produce no fill_we and no done. A fresh ic_miss afterwards fills from idx 0.
- Memory with irregular mem_rvalid gaps (L varies 4–7, order preserved) -> fill_idx 0..7 in order, exactly 8 fill_we, done one cycle after the last word. Miss addr 0xFFF2 -> reads 0xFFF0–0xFFFE.
